// File: rtl/brus16_pkg.sv
// Shared constants and the fetch entry type for the brus16 fetch stage.
package brus16_pkg;

  localparam int ADDR_W  = 13;
  localparam int INSTR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 13'h0;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/brus16_fetch_fifo.sv
// Synchronous skid FIFO of fetch entries; flush wins over push and pop.
module brus16_fetch_fifo
  import brus16_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push & ~flush;
    do_pop   = pop & ~flush & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/brus16_fetch.sv
// brus16 instruction fetch stage: PC, ROM issue with credit check, skid FIFO, bypass.
// Optional perf counters built only when BRUS16_FETCH_PERF_EN is defined.
module brus16_fetch
  import brus16_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_ad,
  output logic               rom_ce,
  output logic               rom_oce,
  output logic               rom_reset,
  input  logic [INSTR_W-1:0] rom_dout,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(BUF_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] tag_q, tag_d;

  fetch_entry_t      fifo_head, ret_entry, out_entry;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_push, fifo_pop;
  logic              valid_raw, pop, issue;
  logic [CNT_W:0]    occ;

  brus16_fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .din   (ret_entry),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_comb begin
    ret_entry       = '0;
    ret_entry.pc    = tag_q;
    ret_entry.instr = rom_dout;

    // FIFO head has priority; the returning ROM word bypasses only into an empty FIFO.
    out_entry = '0;
    if (!fifo_empty)     out_entry = fifo_head;
    else if (inflight_q) out_entry = ret_entry;

    valid_raw   = ~fifo_empty | inflight_q;
    instr_valid = valid_raw & ~reset;
    instr       = reset ? '0 : out_entry.instr;
    instr_pc    = reset ? '0 : out_entry.pc;
    pop         = instr_valid & instr_ready;

    fifo_pop  = pop & ~fifo_empty;
    fifo_push = inflight_q & ~(fifo_empty & pop);

    occ   = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    issue = ~reset & ~redirect_valid & (occ < DEPTH_L);

    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d  = pc_q + 1'b1;
      tag_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  assign rom_ad    = pc_q;
  assign rom_ce    = issue;
  assign rom_oce   = 1'b1;
  assign rom_reset = reset;

`ifdef BRUS16_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, pop};
    perf_stall_d   = perf_stall_q + {31'd0, instr_valid & ~instr_ready};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule
